// File: rtl/hazard_scoreboard.sv
// Per-register in-flight producer scoreboard: detects RAW hazards, selects forwarding age, drives stall/flush.
// Optional macro HAZARD_SB_STATS_EN enables the cumulative stall_cnt counter (tied to 0 otherwise).
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int DEPTH   = 3,
    parameter int MAX_LAT = 3,
    localparam int RW     = $clog2(NREG),
    localparam int AW     = $clog2(DEPTH + 1),
    localparam int LW     = $clog2(MAX_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_ID,
    input  logic          rdwr_ID,
    input  logic [RW-1:0] rd_ID,
    input  logic [LW-1:0] lat_ID,
    input  logic          rs1use_ID,
    input  logic          rs2use_ID,
    input  logic [RW-1:0] rs1_ID,
    input  logic [RW-1:0] rs2_ID,
    input  logic          Branch_ID,
    output logic          PC_EN_IF,
    output logic          reg_FD_stall,
    output logic          reg_FD_flush,
    output logic          reg_DE_flush,
    output logic [AW-1:0] forward_ctrl_A,
    output logic [AW-1:0] forward_ctrl_B,
    output logic [31:0]   stall_cnt
);

    localparam int CW = (AW > LW) ? AW : LW;

    logic          valid_q [NREG];
    logic          valid_d [NREG];
    logic [AW-1:0] age_q   [NREG];
    logic [AW-1:0] age_d   [NREG];
    logic [LW-1:0] lat_q   [NREG];
    logic [LW-1:0] lat_d   [NREG];

    logic          stall;
    logic          issue_fire;

    logic [RW-1:0] src_reg [2];
    logic          src_use [2];
    logic          src_haz [2];
    logic [AW-1:0] src_fwd [2];

    assign issue_fire = issue_ID & ~stall;

    // Entry 0 never tracks anything: x0 reads always come from the register file.
    assign valid_d[0] = 1'b0;
    assign age_d[0]   = '0;
    assign lat_d[0]   = '0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_entry
            logic load;
            logic expire;

            // A fresh issue to this register overrides aging: youngest producer wins.
            assign load         = issue_fire & rdwr_ID & (rd_ID == RW'(gi));
            assign expire       = valid_q[gi] & (age_q[gi] == AW'(DEPTH));
            assign valid_d[gi]  = load | (valid_q[gi] & ~expire);
            assign age_d[gi]    = load ? AW'(1)
                                : (valid_q[gi] & ~expire) ? age_q[gi] + AW'(1)
                                : '0;
            assign lat_d[gi]    = load ? lat_ID : (valid_d[gi] ? lat_q[gi] : '0);
        end
    endgenerate

    assign src_reg[0] = rs1_ID;
    assign src_reg[1] = rs2_ID;
    assign src_use[0] = rs1use_ID;
    assign src_use[1] = rs2use_ID;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic live;
            logic early;

            // Uses the pre-issue state, so an ID instruction never forwards from itself.
            assign live        = src_use[gi] & (src_reg[gi] != '0) & valid_q[src_reg[gi]];
            assign early       = CW'(age_q[src_reg[gi]]) < CW'(lat_q[src_reg[gi]]);
            assign src_haz[gi] = live & early;
            assign src_fwd[gi] = (live & ~early) ? age_q[src_reg[gi]] : '0;
        end
    endgenerate

    assign stall          = src_haz[0] | src_haz[1];
    assign PC_EN_IF       = ~stall;
    assign reg_FD_stall   = stall;
    assign reg_DE_flush   = stall;
    assign reg_FD_flush   = Branch_ID & ~stall;
    assign forward_ctrl_A = src_fwd[0];
    assign forward_ctrl_B = src_fwd[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                valid_q[i] <= 1'b0;
                age_q[i]   <= '0;
                lat_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                valid_q[i] <= valid_d[i];
                age_q[i]   <= age_d[i];
                lat_q[i]   <= lat_d[i];
            end
        end
    end

`ifdef HAZARD_SB_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    assign stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus randomized traffic against a timestamp-based model.
module tb_hazard_scoreboard;

    localparam int NREG    = 32;
    localparam int DEPTH   = 3;
    localparam int MAX_LAT = 3;
    localparam int RW      = $clog2(NREG);
    localparam int AW      = $clog2(DEPTH + 1);
    localparam int LW      = $clog2(MAX_LAT + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_ID;
    logic          rdwr_ID;
    logic [RW-1:0] rd_ID;
    logic [LW-1:0] lat_ID;
    logic          rs1use_ID;
    logic          rs2use_ID;
    logic [RW-1:0] rs1_ID;
    logic [RW-1:0] rs2_ID;
    logic          Branch_ID;
    logic          PC_EN_IF;
    logic          reg_FD_stall;
    logic          reg_FD_flush;
    logic          reg_DE_flush;
    logic [AW-1:0] forward_ctrl_A;
    logic [AW-1:0] forward_ctrl_B;
    logic [31:0]   stall_cnt;

    hazard_scoreboard #(.NREG(NREG), .DEPTH(DEPTH), .MAX_LAT(MAX_LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_ID       (issue_ID),
        .rdwr_ID        (rdwr_ID),
        .rd_ID          (rd_ID),
        .lat_ID         (lat_ID),
        .rs1use_ID      (rs1use_ID),
        .rs2use_ID      (rs2use_ID),
        .rs1_ID         (rs1_ID),
        .rs2_ID         (rs2_ID),
        .Branch_ID      (Branch_ID),
        .PC_EN_IF       (PC_EN_IF),
        .reg_FD_stall   (reg_FD_stall),
        .reg_FD_flush   (reg_FD_flush),
        .reg_DE_flush   (reg_DE_flush),
        .forward_ctrl_A (forward_ctrl_A),
        .forward_ctrl_B (forward_ctrl_B),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: remember the cycle number each register's youngest producer issued in.
    int cyc = 0;
    int issue_cyc [NREG];
    int m_lat     [NREG];
    bit issued    [NREG];
    int m_cnt = 0;

    function automatic int m_age(int r);
        int a;
        if (r == 0 || !issued[r]) return 0;
        a = cyc - issue_cyc[r];
        return (a >= 1 && a <= DEPTH) ? a : 0;
    endfunction

    function automatic bit m_haz(bit use_s, int r);
        int a;
        a = m_age(r);
        return use_s && a != 0 && a < m_lat[r];
    endfunction

    function automatic int m_fwd(bit use_s, int r);
        int a;
        a = m_age(r);
        return (use_s && a != 0 && a >= m_lat[r]) ? a : 0;
    endfunction

    function automatic int exp_cnt();
`ifdef HAZARD_SB_STATS_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic set_in(input bit iss, input bit wr, input int rd, input int lat,
                          input bit u1, input int s1, input bit u2, input int s2, input bit br);
        issue_ID  = iss;
        rdwr_ID   = wr;
        rd_ID     = RW'(rd);
        lat_ID    = LW'(lat);
        rs1use_ID = u1;
        rs1_ID    = RW'(s1);
        rs2use_ID = u2;
        rs2_ID    = RW'(s2);
        Branch_ID = br;
        #1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic step();
        bit ms;
        ms = m_haz(rs1use_ID, int'(rs1_ID)) | m_haz(rs2use_ID, int'(rs2_ID));
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NREG; r++) issued[r] = 0;
            m_cnt = 0;
        end else begin
            if (ms) m_cnt++;
            if (issue_ID && !ms && rdwr_ID && rd_ID != 0) begin
                issued[rd_ID]    = 1;
                issue_cyc[rd_ID] = cyc;
                m_lat[rd_ID]     = int'(lat_ID);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        #1;
        $display("reset: pc_en=%0b fd_stall=%0b de_flush=%0b fd_flush=%0b fa=%0d fb=%0d cnt=%0d",
                 PC_EN_IF, reg_FD_stall, reg_DE_flush, reg_FD_flush, forward_ctrl_A, forward_ctrl_B, stall_cnt);
        n_checks++; if (PC_EN_IF !== 1'b1) $display("FAIL reset_pc_en: got %0b want 1", PC_EN_IF); else n_pass++;
        n_checks++; if ({reg_FD_stall, reg_FD_flush, reg_DE_flush} !== 3'b000)
            $display("FAIL reset_ctl: got %b want 000", {reg_FD_stall, reg_FD_flush, reg_DE_flush}); else n_pass++;
        n_checks++; if (forward_ctrl_A !== '0 || forward_ctrl_B !== '0)
            $display("FAIL reset_fwd: got %0d/%0d want 0/0", forward_ctrl_A, forward_ctrl_B); else n_pass++;
        n_checks++; if (stall_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d want 0", stall_cnt); else n_pass++;
    endtask

    task automatic test_alu_forward();
        set_in(1, 1, 5, 1, 0, 0, 0, 0, 0);
        step();
        set_in(1, 0, 0, 1, 1, 5, 0, 0, 0);
        $display("alu_forward: pc_en=%0b fa=%0d", PC_EN_IF, forward_ctrl_A);
        n_checks++; if (PC_EN_IF !== 1'b1) $display("FAIL alu_no_stall: got pc_en %0b want 1", PC_EN_IF); else n_pass++;
        n_checks++; if (forward_ctrl_A !== AW'(1)) $display("FAIL alu_fwd_a: got %0d want 1", forward_ctrl_A); else n_pass++;
        step();
        idle();
        repeat (DEPTH) step();
    endtask

    task automatic test_load_use();
        set_in(1, 1, 6, 2, 0, 0, 0, 0, 0);
        step();
        set_in(1, 0, 0, 1, 0, 0, 1, 6, 0);
        $display("load_use stall: pc_en=%0b de_flush=%0b", PC_EN_IF, reg_DE_flush);
        n_checks++; if (PC_EN_IF !== 1'b0) $display("FAIL load_use_pc_en: got %0b want 0", PC_EN_IF); else n_pass++;
        n_checks++; if (reg_DE_flush !== 1'b1) $display("FAIL load_use_de_flush: got %0b want 1", reg_DE_flush); else n_pass++;
        step();
        $display("load_use release: pc_en=%0b fb=%0d", PC_EN_IF, forward_ctrl_B);
        n_checks++; if (PC_EN_IF !== 1'b1) $display("FAIL load_use_release: got pc_en %0b want 1", PC_EN_IF); else n_pass++;
        n_checks++; if (forward_ctrl_B !== AW'(2)) $display("FAIL load_use_fwd_b: got %0d want 2", forward_ctrl_B); else n_pass++;
        step();
        idle();
        repeat (DEPTH) step();
    endtask

    task automatic test_long_latency();
        set_in(1, 1, 7, 3, 0, 0, 0, 0, 0);
        step();
        set_in(1, 0, 0, 1, 1, 7, 0, 0, 0);
        for (int k = 0; k < DEPTH - 1; k++) begin
            $display("long_lat stall %0d: fd_stall=%0b", k, reg_FD_stall);
            n_checks++; if (reg_FD_stall !== 1'b1) $display("FAIL long_lat_stall%0d: got %0b want 1", k, reg_FD_stall); else n_pass++;
            step();
        end
        $display("long_lat release: fd_stall=%0b fa=%0d", reg_FD_stall, forward_ctrl_A);
        n_checks++; if (reg_FD_stall !== 1'b0) $display("FAIL long_lat_release: got %0b want 0", reg_FD_stall); else n_pass++;
        n_checks++; if (forward_ctrl_A !== AW'(3)) $display("FAIL long_lat_fwd_a: got %0d want 3", forward_ctrl_A); else n_pass++;
        step();
        $display("long_lat age4: fa=%0d", forward_ctrl_A);
        n_checks++; if (forward_ctrl_A !== '0) $display("FAIL long_lat_expired: got %0d want 0", forward_ctrl_A); else n_pass++;
`ifdef HAZARD_SB_STATS_EN
        n_checks++; if (stall_cnt !== 32'd3) $display("FAIL stall_cnt_total: got %0d want 3", stall_cnt); else n_pass++;
`else
        n_checks++; if (stall_cnt !== 32'd0) $display("FAIL stall_cnt_total: got %0d want 0", stall_cnt); else n_pass++;
`endif
        step();
        idle();
        repeat (DEPTH) step();
    endtask

    task automatic test_branch_stall();
        set_in(1, 1, 8, 2, 0, 0, 0, 0, 0);
        step();
        set_in(1, 0, 0, 1, 1, 8, 0, 0, 1);
        $display("branch stall: fd_flush=%0b fd_stall=%0b", reg_FD_flush, reg_FD_stall);
        n_checks++; if (reg_FD_flush !== 1'b0) $display("FAIL branch_flush_in_stall: got %0b want 0", reg_FD_flush); else n_pass++;
        n_checks++; if (reg_FD_stall !== 1'b1) $display("FAIL branch_stall: got %0b want 1", reg_FD_stall); else n_pass++;
        step();
        $display("branch release: fd_flush=%0b", reg_FD_flush);
        n_checks++; if (reg_FD_flush !== 1'b1) $display("FAIL branch_flush_release: got %0b want 1", reg_FD_flush); else n_pass++;
        step();
        idle();
        repeat (DEPTH) step();
    endtask

    task automatic test_x0_and_reset();
        set_in(1, 1, 0, 3, 0, 0, 0, 0, 0);
        step();
        set_in(1, 0, 0, 1, 1, 0, 1, 0, 0);
        $display("x0: pc_en=%0b fa=%0d fb=%0d", PC_EN_IF, forward_ctrl_A, forward_ctrl_B);
        n_checks++; if (PC_EN_IF !== 1'b1) $display("FAIL x0_no_stall: got pc_en %0b want 1", PC_EN_IF); else n_pass++;
        n_checks++; if (forward_ctrl_A !== '0 || forward_ctrl_B !== '0)
            $display("FAIL x0_fwd: got %0d/%0d want 0/0", forward_ctrl_A, forward_ctrl_B); else n_pass++;
        step();
        // Same-cycle write and read of x10 must not see itself.
        set_in(1, 1, 10, 1, 1, 10, 0, 0, 0);
        n_checks++; if (forward_ctrl_A !== '0 || PC_EN_IF !== 1'b1)
            $display("FAIL self_fwd: got fa=%0d pc_en=%0b want 0/1", forward_ctrl_A, PC_EN_IF); else n_pass++;
        step();
        set_in(1, 1, 9, 2, 0, 0, 0, 0, 0);
        step();
        set_in(1, 0, 0, 1, 1, 9, 0, 0, 0);
        n_checks++; if (reg_FD_stall !== 1'b1) $display("FAIL rst_mid_stall_pre: got %0b want 1", reg_FD_stall); else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        $display("reset mid-stall: fd_stall=%0b fa=%0d cnt=%0d", reg_FD_stall, forward_ctrl_A, stall_cnt);
        n_checks++; if (reg_FD_stall !== 1'b0) $display("FAIL rst_mid_stall: got %0b want 0", reg_FD_stall); else n_pass++;
        n_checks++; if (stall_cnt !== 32'd0) $display("FAIL rst_cnt_clear: got %0d want 0", stall_cnt); else n_pass++;
        step();
        idle();
    endtask

    task automatic test_random();
        int rd, s1, s2, lat;
        bit iss, wr, u1, u2, br, ms;
        for (int t = 0; t < 400; t++) begin
            rst = ($urandom_range(0, 39) == 0);
            iss = ($urandom_range(0, 3) != 0);
            wr  = $urandom_range(0, 1);
            rd  = $urandom_range(0, 7);
            lat = $urandom_range(1, MAX_LAT);
            u1  = $urandom_range(0, 1);
            s1  = $urandom_range(0, 7);
            u2  = $urandom_range(0, 1);
            s2  = $urandom_range(0, 7);
            br  = ($urandom_range(0, 4) == 0);
            set_in(iss, wr, rd, lat, u1, s1, u2, s2, br);
            ms = m_haz(u1, s1) | m_haz(u2, s2);
            $display("rand %0d: rst=%0b iss=%0b wr=%0b rd=%0d lat=%0d rs1=%0d/%0b rs2=%0d/%0b br=%0b -> stall=%0b fa=%0d fb=%0d",
                     t, rst, iss, wr, rd, lat, s1, u1, s2, u2, br, reg_FD_stall, forward_ctrl_A, forward_ctrl_B);
            n_checks++; if ({PC_EN_IF, reg_FD_stall, reg_DE_flush} !== {~ms, ms, ms})
                $display("FAIL rand_stall t=%0d: got %b want %b", t, {PC_EN_IF, reg_FD_stall, reg_DE_flush}, {~ms, ms, ms}); else n_pass++;
            n_checks++; if (reg_FD_flush !== (br & ~ms))
                $display("FAIL rand_fd_flush t=%0d: got %0b want %0b", t, reg_FD_flush, br & ~ms); else n_pass++;
            n_checks++; if (forward_ctrl_A !== AW'(m_fwd(u1, s1)))
                $display("FAIL rand_fwd_a t=%0d: got %0d want %0d", t, forward_ctrl_A, m_fwd(u1, s1)); else n_pass++;
            n_checks++; if (forward_ctrl_B !== AW'(m_fwd(u2, s2)))
                $display("FAIL rand_fwd_b t=%0d: got %0d want %0d", t, forward_ctrl_B, m_fwd(u2, s2)); else n_pass++;
            n_checks++; if (stall_cnt !== 32'(exp_cnt()))
                $display("FAIL rand_cnt t=%0d: got %0d want %0d", t, stall_cnt, exp_cnt()); else n_pass++;
            step();
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin
            issued[r]    = 0;
            issue_cyc[r] = 0;
            m_lat[r]     = 0;
        end
        rst = 1'b1;
        idle();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_long_latency();
        test_branch_stall();
        test_x0_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
